gmii_rx_interface: RTL

Receive-direction framer between gmii_to_rgmii (gmii_rx_data/en/er outputs) and the RX afifo write port. It strips preamble/SFD, writes frame bytes (including FCS) into the FIFO, checks CRC-32, and reports each frame's length and status through a ready/ack handshake. It mirrors the TX-side gmii_interface word_count_ready/word_count_ack scheme.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_rx_interface.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, status bit positions and RX framer states.
// Pure declarations: no latency, no backpressure.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

    localparam int ST_CRC_ERR  = 4;
    localparam int ST_RX_ERR   = 3;
    localparam int ST_RUNT     = 2;
    localparam int ST_LONG     = 1;
    localparam int ST_FIFO_OVF = 0;

    typedef enum logic [1:0] {
        DROP = 2'd0,
        IDLE = 2'd1,
        PRE  = 2'd2,
        DATA = 2'd3
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 next-state for one byte, LSB first; purely combinational (0 cycles).
// No backpressure: the caller decides when to register the result.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc_in;
        for (int b = 0; b < 8; b++) begin
            w_crc = (w_crc >> 1) ^ (CRC_POLY & {32{w_crc[0] ^ i_data[b]}});
        end
        o_crc_out = w_crc;
    end

endmodule

// File: rtl/gmii_rx_interface.sv
// GMII RX framer: strips preamble/SFD, writes bytes to the RX FIFO 1 cycle after sampling, checks FCS.
// A full FIFO drops bytes (fifo_ovf); frames arriving while the previous status is unacked are dropped.
module gmii_rx_interface
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int PRE_MAX = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rx_data,
    input  logic        gmii_rx_en,
    input  logic        gmii_rx_er,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [7:0]  fifo_data,
    output logic [10:0] frame_len,
    output logic [4:0]  frame_status,
    output logic        frame_ready,
    input  logic        frame_ack,
    output logic [7:0]  drop_count
);

    localparam int          PRE_W      = $clog2(PRE_MAX + 1);
    localparam logic [PRE_W-1:0] LP_PRE_MAX = PRE_W'(PRE_MAX);
    localparam logic [10:0] LP_MAX_LEN = 11'(MAX_LEN);
    localparam logic [10:0] LP_MIN_LEN = 11'(MIN_LEN);

    rx_state_t        r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [10:0]      r_len;
    logic [10:0]      r_rx_cnt;
    logic             r_rx_err;
    logic             r_long;
    logic             r_ovf;
    logic [31:0]      r_crc;
    logic             r_fifo_wr;
    logic [7:0]       r_fifo_data;
    logic [10:0]      r_frame_len;
    logic [4:0]       r_frame_status;
    logic             r_frame_ready;
    logic [7:0]       r_drop_count;

    logic [31:0]      w_crc_next;
    logic [7:0]       w_drop_next;
    logic [4:0]       w_status;

    crc32_d8 u_crc (
        .i_crc_in  (r_crc),
        .i_data    (gmii_rx_data),
        .o_crc_out (w_crc_next)
    );

    assign w_drop_next = (r_drop_count == 8'hFF) ? 8'hFF : r_drop_count + 8'd1;

    always_comb begin
        w_status              = '0;
        w_status[ST_CRC_ERR]  = (r_crc != CRC_RESIDUE);
        w_status[ST_RX_ERR]   = r_rx_err;
        w_status[ST_RUNT]     = (r_rx_cnt < LP_MIN_LEN);
        w_status[ST_LONG]     = r_long;
        w_status[ST_FIFO_OVF] = r_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= DROP;
            r_pre_cnt      <= '0;
            r_len          <= '0;
            r_rx_cnt       <= '0;
            r_rx_err       <= 1'b0;
            r_long         <= 1'b0;
            r_ovf          <= 1'b0;
            r_crc          <= CRC_INIT;
            r_fifo_wr      <= 1'b0;
            r_fifo_data    <= '0;
            r_frame_len    <= '0;
            r_frame_status <= '0;
            r_frame_ready  <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            r_fifo_wr <= 1'b0;
            // An end-of-frame below on the same edge overrides this clear.
            if (r_frame_ready && frame_ack) begin
                r_frame_ready <= 1'b0;
            end
            case (r_state)
                DROP: begin
                    if (!gmii_rx_en) r_state <= IDLE;
                end
                IDLE: begin
                    if (gmii_rx_en) begin
                        if (!gmii_rx_er && gmii_rx_data == ETH_PREAMBLE) begin
                            r_state   <= PRE;
                            r_pre_cnt <= PRE_W'(1);
                        end else begin
                            r_state      <= DROP;
                            r_drop_count <= w_drop_next;
                        end
                    end
                end
                PRE: begin
                    if (!gmii_rx_en) begin
                        r_state <= IDLE;
                    end else if (!gmii_rx_er && gmii_rx_data == ETH_PREAMBLE
                                 && r_pre_cnt < LP_PRE_MAX) begin
                        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
                    end else if (!gmii_rx_er && gmii_rx_data == ETH_SFD && !r_frame_ready) begin
                        r_state  <= DATA;
                        r_len    <= '0;
                        r_rx_cnt <= '0;
                        r_rx_err <= 1'b0;
                        r_long   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_crc    <= CRC_INIT;
                    end else begin
                        r_state      <= DROP;
                        r_drop_count <= w_drop_next;
                    end
                end
                DATA: begin
                    if (gmii_rx_en) begin
                        r_crc <= w_crc_next;
                        if (r_rx_cnt != 11'h7FF) r_rx_cnt <= r_rx_cnt + 11'd1;
                        if (gmii_rx_er) r_rx_err <= 1'b1;
                        if (r_len < LP_MAX_LEN) begin
                            if (!fifo_full) begin
                                r_fifo_wr   <= 1'b1;
                                r_fifo_data <= gmii_rx_data;
                                r_len       <= r_len + 11'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end else begin
                            r_long <= 1'b1;
                        end
                    end else begin
                        r_frame_len    <= r_len;
                        r_frame_status <= w_status;
                        r_frame_ready  <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= DROP;
            endcase
        end
    end

    assign fifo_wr      = r_fifo_wr;
    assign fifo_data    = r_fifo_data;
    assign frame_len    = r_frame_len;
    assign frame_status = r_frame_status;
    assign frame_ready  = r_frame_ready;
    assign drop_count   = r_drop_count;

endmodule
